// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 4-digit seven-segment display:
// blanking patterns, scan index width and the active-low hex font.
package seg_pkg;

  localparam int IDX_W = 2;

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Segments g..a, active-low; element n is the glyph for hex digit n.
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/btn_debounce.sv
// One push-button conditioner: 2-FF synchronizer, stability counter and a
// single-cycle press pulse on each accepted 0->1 transition.
module btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             press_q, press_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
    end
  end

  // The counter tracks how long the synced level has disagreed with the
  // accepted one; any agreement restarts the count, so bounces are dropped.
  always_comb begin
    sync_d   = {sync_q[0], raw};
    cnt_d    = cnt_q;
    stable_d = stable_q;
    press_d  = 1'b0;
    if (sync_q[1] == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
      cnt_d    = '0;
      stable_d = sync_q[1];
      press_d  = sync_q[1];
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign level = stable_q;
  assign press = press_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Round-robin scan scheduler for the shared 4-digit display, with four
// button-incremented hex digit registers and registered AN/SEGMENT pins.
module seg_scan_ctrl #(
  parameter int SCAN_DIV   = 100000,
  parameter int DEB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic [7:0] SW,
  output logic [3:0] AN,
  output logic [7:0] SEGMENT,
  output logic       BTNX4
);

  import seg_pkg::*;

  localparam int SLOT_W = $clog2(SCAN_DIV);

  logic [3:0]        btn_level;
  logic [3:0]        btn_press;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [3:0]        digit_q [4];
  logic [3:0]        digit_d [4];
  logic [3:0]        an_q, an_d;
  logic [7:0]        seg_q, seg_d;
  logic [3:0]        dp_en;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn[i]),
      .level (btn_level[i]),
      .press (btn_press[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      slot_q <= '0;
      for (int i = 0; i < 4; i++) digit_q[i] <= '0;
      an_q   <= AN_OFF;
      seg_q  <= SEG_OFF;
    end else begin
      idx_q  <= idx_d;
      slot_q <= slot_d;
      for (int i = 0; i < 4; i++) digit_q[i] <= digit_d[i];
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign dp_en = SW[7:4];

  always_comb begin
    idx_d  = idx_q;
    slot_d = slot_q + SLOT_W'(1);
    if (slot_q == SLOT_W'(SCAN_DIV - 1)) begin
      slot_d = '0;
      idx_d  = idx_q + IDX_W'(1);
    end

    for (int i = 0; i < 4; i++) begin
      digit_d[i] = digit_q[i];
      if (btn_press[i]) digit_d[i] = digit_q[i] + 4'd1;
    end

    // Slot cycle 0 is always dark so the previous digit cannot ghost;
    // disabled digits still consume their full slot.
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (slot_q != '0 && SW[idx_q]) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = {~dp_en[idx_q], HEX_FONT[digit_q[idx_q]]};
    end
  end

  assign AN      = an_q;
  assign SEGMENT = seg_q;
  assign BTNX4   = 1'b0;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a cycle model of the scan predicts
// every registered output, masking only digits whose buttons are settling.
module tb_seg_scan_ctrl;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
    logic       seg_chk;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic [7:0] SW;
  logic [3:0] AN;
  logic [7:0] SEGMENT;
  logic       BTNX4;

  exp_t       sb_q[$];
  exp_t       e_pop;
  exp_t       e_push;
  int         vectors = 0;
  int         miscompares = 0;

  logic [1:0] m_idx;
  int         m_slot;
  logic [3:0] m_digit [4];
  logic [3:0] flux;

  seg_scan_ctrl #(.SCAN_DIV(4), .DEB_CYCLES(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn),
    .SW      (SW),
    .AN      (AN),
    .SEGMENT (SEGMENT),
    .BTNX4   (BTNX4)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] font(input logic [3:0] d);
    case (d)
      4'h0: font = 7'h40;  4'h1: font = 7'h79;  4'h2: font = 7'h24;  4'h3: font = 7'h30;
      4'h4: font = 7'h19;  4'h5: font = 7'h12;  4'h6: font = 7'h02;  4'h7: font = 7'h78;
      4'h8: font = 7'h00;  4'h9: font = 7'h10;  4'hA: font = 7'h08;  4'hB: font = 7'h03;
      4'hC: font = 7'h46;  4'hD: font = 7'h21;  4'hE: font = 7'h06;  default: font = 7'h0E;
    endcase
  endfunction

  // Reference scan: predict what the output register loads at this edge.
  always @(posedge clk) begin
    if (rst) begin
      m_idx  = 2'd0;
      m_slot = 0;
    end else begin
      e_push.an      = 4'b1111;
      e_push.seg     = 8'hFF;
      e_push.seg_chk = 1'b1;
      if (m_slot != 0 && SW[m_idx]) begin
        e_push.an      = ~(4'b0001 << m_idx);
        e_push.seg     = {~SW[4 + m_idx], font(m_digit[m_idx])};
        e_push.seg_chk = ~flux[m_idx];
      end
      sb_q.push_back(e_push);
      if (m_slot == 3) begin
        m_slot = 0;
        m_idx  = m_idx + 2'd1;
      end else begin
        m_slot = m_slot + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      e_pop = sb_q.pop_front();
      vectors++;
      assert (AN === e_pop.an) else begin
        miscompares++;
        $error("[TB] FAIL an: observed %b expected %b at %0t", AN, e_pop.an, $time);
      end
      vectors++;
      assert (BTNX4 === 1'b0) else begin
        miscompares++;
        $error("[TB] FAIL btnx4: observed %b expected 0 at %0t", BTNX4, $time);
      end
      if (e_pop.seg_chk) begin
        vectors++;
        assert (SEGMENT === e_pop.seg) else begin
          miscompares++;
          $error("[TB] FAIL segment: observed %h expected %h at %0t", SEGMENT, e_pop.seg, $time);
        end
      end
    end
  end

  task automatic checkOutput(input string tag);
    vectors++;
    assert (AN === 4'b1111 && SEGMENT === 8'hFF && BTNX4 === 1'b0) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed AN=%b SEG=%h BTNX4=%b expected AN=1111 SEG=ff BTNX4=0",
             tag, AN, SEGMENT, BTNX4);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] mask, input int hold);
    flux = flux | mask;
    btn  = mask;
    repeat (hold) @(negedge clk);
    btn = 4'h0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++)
      if (mask[i]) m_digit[i] = m_digit[i] + 4'd1;
    flux = flux & ~mask;
  endtask

  task automatic doReset(input string tag);
    rst = 1'b1;
    sb_q.delete();
    for (int i = 0; i < 4; i++) m_digit[i] = 4'h0;
    flux = 4'h0;
    #1;
    checkOutput(tag);
  endtask

  initial begin
    btn = 4'h0;
    SW  = 8'h0F;
    for (int i = 0; i < 4; i++) m_digit[i] = 4'h0;
    flux = 4'h0;
    m_idx = 2'd0;
    m_slot = 0;
    rst = 1'b1;
    #2;
    checkOutput("reset_initial");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Plain scan of four zero digits over two full periods.
    repeat (34) @(negedge clk);

    // Long hold of btn[2]: one increment only.
    applyStimulus(4'b0100, 20);
    repeat (20) @(negedge clk);

    // Single-cycle bounces on btn[0] must never be accepted.
    btn = 4'b0001; @(negedge clk);
    btn = 4'b0000; @(negedge clk);
    btn = 4'b0001; @(negedge clk);
    btn = 4'b0000;
    repeat (20) @(negedge clk);

    // Sixteen clean presses walk digit 0 through F and back to 0.
    for (int p = 0; p < 16; p++) begin
      applyStimulus(4'b0001, 8);
      repeat (16) @(negedge clk);
    end

    // All four buttons at once, with digits 1 and 3 blanked and every dp lit.
    #1;
    doReset("reset_between");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    SW  = 8'hF5;
    applyStimulus(4'b1111, 8);
    repeat (34) @(negedge clk);

    // Reset mid-slot while btn[1] is partway through debouncing.
    SW  = 8'h0F;
    btn = 4'b0010;
    repeat (3) @(negedge clk);
    #1;
    doReset("reset_midslot");
    btn = 4'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexing scheduler for the board's shared 4-digit, 7-segment display. It owns four 4-bit digit registers, edited by debounced push-buttons. It grants the shared SEGMENT bus to one digit at a time in round-robin order, driving the matching AN line. It sits between the raw board I/O (SW, btn) and the display pins, replacing the ad-hoc logic in the display top level.

Parameters:
SCAN_DIV, 100000, clock cycles each digit owns the display (slot length, >=2)
DEB_CYCLES, 500000, consecutive stable cycles required before a button level is accepted (>=1)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
btn  input  4  raw push-buttons, active-high, asynchronous to clk; btn[i] edits digit i
SW  input  8  SW[3:0] digit enable (1 = digit i shown); SW[7:4] decimal point on for digit i
AN  output  4  digit anodes, active-low, at most one low at any time
SEGMENT  output  8  SEGMENT[6:0] = g..a, SEGMENT[7] = dp, all active-low
BTNX4  output  1  button-matrix column drive, constant 0

Behaviour:
- Reset (async, rst=1):
  - digit[0..3] = 0; scan index = 0; slot counter = 0
  - debounce stable levels = 0; debounce counters = 0
  - AN = 4'b1111; SEGMENT = 8'hFF; BTNX4 = 0
  - Assertion mid-slot or mid-debounce aborts immediately with no increment.
- Button path, per bit i, identical and independent:
  - 2-FF synchronizer.
  - Counter resets whenever the synced level equals the stable level; otherwise it counts.
  - At DEB_CYCLES consecutive differing cycles, stable <= synced and the counter clears.
  - A 0->1 stable transition emits a one-cycle press pulse.
  - Press pulse -> digit[i] <= digit[i]+1, mod 16 (F wraps to 0).
  - Holding a button gives exactly one increment; release gives none.
  - Bounces shorter than DEB_CYCLES are ignored.
  - Simultaneous pulses on several bits increment all their digits in the same cycle.
- Scan scheduler:
  - Slot counter runs 0..SCAN_DIV-1.
  - At SCAN_DIV-1 the counter wraps to 0 and the index advances 0->1->2->3->0.
- Outputs are registered: one cycle of latency from (index, counter, digit, SW) to the pins.
  - Counter == 0 (anti-ghost blank cycle): AN = 4'b1111, SEGMENT = 8'hFF.
  - Counter != 0 and SW[idx] = 1: AN = ~(1<<idx).
    - SEGMENT[6:0] = hex font of digit[idx].
    - SEGMENT[7] = ~SW[4+idx].
  - Counter != 0 and SW[idx] = 0: AN = 4'b1111, SEGMENT = 8'hFF. The slot is still consumed, so timing does not depend on SW.
- Hex font (g..a, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- A digit increment during its own slot appears on the next registered output cycle. There is no slot restart.
- SW is sampled every cycle; no synchronizer is needed beyond the output register (static switches).

Decomposition:
- Shared package seg_pkg holds:
  - the hex-font constant array
  - AN_OFF = 4'b1111 and SEG_OFF = 8'hFF
  - the digit index width (2)
- One sub-module, btn_debounce (parameter DEB_CYCLES; ports clk, rst, raw, level, press), instantiated 4 times.
- Scan counter, digit registers and output register stay in seg_scan_ctrl.

Test Plan:
- Bench parameters: SCAN_DIV=4, DEB_CYCLES=3 for all scenarios.
- Reset then release, SW=8'h0F, btn=0 -> AN cycles 1111,1110,1110,1110,1111,1101,... (period 16); SEGMENT=8'hC0 in lit cycles; BTNX4=0 throughout.
- Hold btn[2]=1 for 20 cycles with SW=8'h0F -> exactly one increment. In digit-2 lit cycles AN=1011 and SEGMENT=8'hF9. Digits 0, 1, 3 stay 8'hC0.
- Bounce btn[0] 1,0,1,0 at 1-cycle spacing, then 0 -> no increment. 16 clean presses of btn[0] -> digit0 wraps F->0 and SEGMENT returns to 8'hC0.
- btn=4'hF pressed together, SW=8'hF5 -> all digits become 1 in the same cycle. Slot 0: AN=1110, SEGMENT=8'h79. Slot 1: AN=1111, SEGMENT=8'hFF. Slot 2: AN=1011, SEGMENT=8'h79.
- Assert rst mid-slot with digits non-zero and btn[1] partly debounced -> AN=1111 and SEGMENT=FF immediately. After release, all digits show 8'hC0 and no increment occurs.
